// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin lane multiplexer arbiter.
package mux_arb_pkg;

   localparam int N_REQ        = 4;
   localparam int SEL_W        = 2;
   localparam int DEF_DATA_W   = 2;
   localparam int DEF_MAX_HOLD = 16;
   localparam int HOLD_W       = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder. The search starts at
// last+1 and wraps, so the most recent grantee has the lowest priority.
module rr_pick
   import mux_arb_pkg::*;
(
   input  logic [N_REQ-1:0] req,
   input  logic [SEL_W-1:0] last,
   output logic             found,
   output logic [SEL_W-1:0] idx
);

   logic [SEL_W-1:0] cand;

   // Scan from farthest to nearest so the nearest requester after last wins.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first, so no
      // path leaves it unassigned and no latch is inferred.
      found = 1'b0;
      idx   = last;
      cand  = last;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = SEL_W'(int'(last) + k);
         if (req[cand]) begin
            found = 1'b1;
            idx   = cand;
         end
      end
   end

endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of the 4-to-1 lane multiplexer select.
// Grants one requester at a time, drives sel, and registers the chosen lane
// onto data_out with data_valid.
// Optional feature: define MUX_ARB_TIMEOUT_EN to force rotation after a grant
// has been held MAX_HOLD cycles while others are waiting.
module mux_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int MAX_HOLD = DEF_MAX_HOLD
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] data_in,
   output logic [N_REQ-1:0]        grant,
   output logic [SEL_W-1:0]        sel,
   output logic [DATA_W-1:0]       data_out,
   output logic                    data_valid,
   output logic                    busy
);

   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("mux_rr_arbiter: MAX_HOLD must be within 2..255");
   end

   state_t           state;
   logic [SEL_W-1:0] last;
   logic [N_REQ-1:0] pick_req;
   logic             pick_found;
   logic [SEL_W-1:0] pick_idx;
   logic             hold_expired;
   logic             load_new;
   logic             go_idle;
   logic [DATA_W-1:0] lane_sel;

   // The current grantee is masked so a timeout rotation never re-picks it;
   // in IDLE grant is zero and the full request vector is searched.
   assign pick_req = req & ~grant;
   assign lane_sel = data_in[sel*DATA_W +: DATA_W];

   rr_pick u_rr_pick (
      .req   (pick_req),
      .last  (last),
      .found (pick_found),
      .idx   (pick_idx)
   );

`ifdef MUX_ARB_TIMEOUT_EN
   logic [HOLD_W-1:0] hold_cnt;

   assign hold_expired = (hold_cnt == HOLD_W'(MAX_HOLD - 1));

   // Count cycles the current grant has been held; cleared on every new grant.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hold_cnt <= '0;
      end else if (load_new) begin
         hold_cnt <= '0;
      end else if (state == GRANT && req[sel]) begin
         if (hold_expired)
            hold_cnt <= '0;
         else if (hold_cnt != {HOLD_W{1'b1}})
            hold_cnt <= hold_cnt + 1'b1;
      end
   end
`else
   assign hold_expired = 1'b0;
`endif

   // Decide whether this edge hands the channel to a new winner or goes idle.
   always_comb begin
      load_new = 1'b0;
      go_idle  = 1'b0;
      if (state == IDLE) begin
         load_new = pick_found;
      end else if (!req[sel]) begin
         load_new = pick_found;
         go_idle  = !pick_found;
      end else begin
         load_new = hold_expired && pick_found;
      end
   end

   // FSM with registered grant, select, pointer and data outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         grant      <= '0;
         sel        <= '0;
         last       <= SEL_W'(N_REQ - 1);
         busy       <= 1'b0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         // NOTE: all state here updates with non-blocking assignments so every
         // register samples the pre-edge values of the others.
         data_valid <= |grant;
         if (|grant)
            data_out <= lane_sel;

         if (load_new) begin
            state <= GRANT;
            busy  <= 1'b1;
            grant <= N_REQ'(1) << pick_idx;
            sel   <= pick_idx;
            last  <= pick_idx;
         end else if (go_idle) begin
            state <= IDLE;
            busy  <= 1'b0;
            grant <= '0;
         end
      end
   end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: a cycle model pushes expected
// outputs to a scoreboard queue as each stimulus cycle is driven, and the
// entry is popped and compared after the DUT's clock edge.
module tb_mux_rr_arbiter;

   localparam int DW = 2;
   localparam int MH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [3:0]      req;
   logic [4*DW-1:0] data_in;
   logic [3:0]      grant;
   logic [1:0]      sel;
   logic [DW-1:0]   data_out;
   logic            data_valid;
   logic            busy;

   mux_rr_arbiter #(.DATA_W(DW), .MAX_HOLD(MH)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .data_in    (data_in),
      .grant      (grant),
      .sel        (sel),
      .data_out   (data_out),
      .data_valid (data_valid),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0]    grant;
      logic [1:0]    sel;
      logic [DW-1:0] dout;
      logic          valid;
      logic          busy;
   } exp_t;

   exp_t sb_q[$];
   int   total = 0;
   int   bad   = 0;

   // Reference model state
   logic          m_active;
   logic [1:0]    m_sel;
   logic [1:0]    m_last;
   int            m_hold;
   logic [DW-1:0] m_dout;
   logic          m_valid;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] rr_next(input logic [3:0] r, input logic [1:0] from);
      logic [1:0] c;
      for (int k = 1; k <= 4; k++) begin
         c = 2'((int'(from) + k) % 4);
         if (r[c]) return c;
      end
      return from;
   endfunction

   task automatic model_reset();
      m_active = 1'b0;
      m_sel    = 2'd0;
      m_last   = 2'd3;
      m_hold   = 0;
      m_dout   = '0;
      m_valid  = 1'b0;
   endtask

   task automatic model_edge(input logic [3:0] r, input logic [4*DW-1:0] d);
      logic [3:0] others;
      if (m_active) m_dout = d[m_sel*DW +: DW];
      m_valid = m_active;
      others  = r & ~(4'b0001 << m_sel);
      if (!m_active) begin
         if (r != 4'b0000) begin
            m_active = 1'b1;
            m_sel    = rr_next(r, m_last);
            m_last   = m_sel;
            m_hold   = 0;
         end
      end else if (!r[m_sel]) begin
         if (r != 4'b0000) begin
            m_sel  = rr_next(r, m_last);
            m_last = m_sel;
            m_hold = 0;
         end else begin
            m_active = 1'b0;
         end
      end else begin
`ifdef MUX_ARB_TIMEOUT_EN
         if (m_hold == MH - 1) begin
            m_hold = 0;
            if (others != 4'b0000) begin
               m_sel  = rr_next(others, m_last);
               m_last = m_sel;
            end
         end else if (m_hold < 255) begin
            m_hold = m_hold + 1;
         end
`endif
      end
   endtask

   // Drive one cycle of stimulus, predict, then compare after the edge.
   task automatic step(input logic [3:0] r, input logic [4*DW-1:0] d);
      exp_t e;
      req     = r;
      data_in = d;
      model_edge(r, d);
      e.grant = m_active ? (4'b0001 << m_sel) : 4'b0000;
      e.sel   = m_sel;
      e.dout  = m_dout;
      e.valid = m_valid;
      e.busy  = m_active;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      check("grant", 32'(grant), 32'(e.grant));
      check("sel", 32'(sel), 32'(e.sel));
      check("data_out", 32'(data_out), 32'(e.dout));
      check("data_valid", 32'(data_valid), 32'(e.valid));
      check("busy", 32'(busy), 32'(e.busy));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_grant"}, 32'(grant), 32'h0);
      check({tag, "_sel"}, 32'(sel), 32'h0);
      check({tag, "_dout"}, 32'(data_out), 32'h0);
      check({tag, "_valid"}, 32'(data_valid), 32'h0);
      check({tag, "_busy"}, 32'(busy), 32'h0);
   endtask

   initial begin
      // Reset with random inputs
      rst     = 1'b1;
      req     = 4'($urandom);
      data_in = 8'($urandom);
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         req     = 4'($urandom);
         data_in = 8'($urandom);
         check_reset_outputs("reset");
      end
      rst = 1'b0;

      // Fair rotation: all request, each drops after three cycles of grant
      step(4'b1111, 8'he4);
      for (int i = 0; i < 5; i++) begin
         check("rot_grant", 32'(grant), 32'(4'b0001 << (i % 4)));
         check("rot_busy", 32'(busy), 32'h1);
         step(4'b1111, 8'($urandom));
         step(4'b1111, 8'($urandom));
         step(4'b1111 & ~(4'b0001 << (i % 4)), 8'($urandom));
         check("rot_nobubble", 32'(busy), 32'h1);
      end

      // Release to idle from sole grantee 3
      step(4'b0000, 8'h1b);
      step(4'b1000, 8'h1b);
      check("rel_grant3", 32'(grant), 32'h8);
      step(4'b1000, 8'h1b);
      step(4'b0000, 8'h1b);
      check("rel_idle_grant", 32'(grant), 32'h0);
      check("rel_idle_busy", 32'(busy), 32'h0);
      check("rel_sel_kept", 32'(sel), 32'h3);
      check("rel_valid_still", 32'(data_valid), 32'h1);
      step(4'b0000, 8'h1b);
      check("rel_valid_low", 32'(data_valid), 32'h0);
      check("rel_dout_held", 32'(data_out), 32'h0);

      // Single requester 2 with lane2 = 2'b10
      step(4'b0100, 8'he4);
      check("single_grant", 32'(grant), 32'h4);
      check("single_sel", 32'(sel), 32'h2);
      step(4'b0100, 8'he4);
      check("single_dout", 32'(data_out), 32'h2);
      check("single_valid", 32'(data_valid), 32'h1);

      // Reset mid-grant
      step(4'b0000, 8'he4);
      step(4'b0010, 8'he4);
      check("mid_grant1", 32'(grant), 32'h2);
      step(4'b0010, 8'he4);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async_rst");
      model_reset();
      @(posedge clk);
      #1 req = 4'($urandom);
      check_reset_outputs("rst_hold");
      rst = 1'b0;
      step(4'b0110, 8'he4);
      check("post_rst_first", 32'(grant), 32'h2);

      // Random traffic
      for (int i = 0; i < 60; i++)
         step(4'($urandom), 8'($urandom));

      // Long hold with two requesters
      step(4'b0000, 8'h00);
      step(4'b0000, 8'h00);
      model_reset();
      #2 rst = 1'b1;
      #1 rst = 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
      for (int n = 1; n <= 12; n++) begin
         step(4'b0011, 8'($urandom));
         check("to_alt", 32'(grant), 32'(4'b0001 << (((n - 1) / 4) % 2)));
      end
      step(4'b0000, 8'h00);
      for (int n = 0; n < 10; n++) begin
         step(4'b0001, 8'($urandom));
         check("to_solo", 32'(grant), 32'h1);
      end
`else
      for (int n = 0; n < 12; n++) begin
         step(4'b0011, 8'($urandom));
         check("no_preempt", 32'(grant), 32'h1);
      end
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the board's 4-to-1, 2-bit lane multiplexer between four requesters. It owns the select lines, so the multiplexer is no longer driven directly from switches. It grants one requester at a time, drives `sel` to steer that requester's 2-bit lane, and registers the chosen lane onto the shared output with a valid flag. It sits between the requester sources (switch/key debouncers or other lab FSMs) and the LED output stage.

## Interface
Parameters:
- `DATA_W`, default 2: width of each requester lane and of `data_out`.
- `MAX_HOLD`, default 16: cycles a grant may be held before forced rotation. Used only with `MUX_ARB_TIMEOUT_EN`; legal range 2..255.

Ports:
- `clk`  in  1: single system clock, rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `req`  in  4: request per requester; `req[i]` high means requester i wants the channel.
- `data_in`  in  4*DATA_W: lane i occupies `data_in[i*DATA_W +: DATA_W]`.
- `grant`  out  4: one-hot registered grant, all-zero when idle.
- `sel`  out  2: registered binary index of the current/last grantee; drives the mux select.
- `data_out`  out  DATA_W: registered selected lane.
- `data_valid`  out  1: registered; high when `data_out` holds granted data.
- `busy`  out  1: high while in GRANT.

## Operation
- Reset values: state IDLE, `grant`=0, `sel`=0, `data_out`=0, `data_valid`=0, `busy`=0, RR pointer `last`=3 (first search starts at 0), hold counter=0.
- Round-robin pick: search `req` starting at index `last+1` mod 4, wrapping. The first set bit wins.
- IDLE: if any `req` is set, go to GRANT with the picked index. `grant`, `sel` and `last` are loaded with that index and the hold counter is cleared. Otherwise stay in IDLE.
- GRANT, granted `req[sel]` still high: keep the grant and increment the hold counter (saturating at 255).
- GRANT, granted `req[sel]` low:
  - If another request is pending, switch directly to the next RR winner with no idle bubble.
  - Otherwise return to IDLE, with `grant`=0 and `sel` kept at its last value.
- Data path:
  - Each cycle, `data_out <= data_in` lane selected by the current registered `sel`.
  - `data_valid <= |grant`.
  - In IDLE, `data_out` holds its last value and `data_valid`=0.
- Simultaneous events:
  - Requests arriving in the same cycle are resolved purely by RR order.
  - A new request for the current grantee, arriving while the grantee drops, is not re-granted ahead of other pending requesters.
- `rst` asserted mid-grant: all outputs immediately (asynchronously) take their reset values, and RR fairness history is lost.

## Timing
- Request-to-grant latency: 1 cycle. `req` sampled high at edge k gives `grant`/`sel` valid after edge k.
- Grant-to-data latency: 1 cycle. `data_out`/`data_valid` reflect `data_in` of the grantee one edge after `grant` rises.
- Request drop: the next grant (or IDLE) takes effect at the edge that samples `req[sel]` low.
- Handover: the last data of the old grantee appears one cycle after the handover edge, then the new grantee's data follows with no gap.
- `grant` is never multi-hot. At most one grant transition occurs per clock edge.

## Configuration
- `MUX_ARB_TIMEOUT_EN` defined:
  - When the hold counter reaches `MAX_HOLD-1` and at least one other requester is pending, the arbiter rotates to the next RR winner at the next edge, even though `req[sel]` is still high.
  - If no other requester is pending, the grant is kept and the counter clears.
  - If `req[sel]` drops in the same cycle as the timeout, it is treated as a normal release.
- `MUX_ARB_TIMEOUT_EN` undefined: no preemption; a grant lasts as long as its `req` stays high. The hold counter is not built.

## Structure
- Package `mux_arb_pkg` holds:
  - the state enum (IDLE, GRANT);
  - `N_REQ`=4 and `SEL_W`=2;
  - the default `DATA_W` and `MAX_HOLD` constants.
- One sub-module, `rr_pick`: combinational rotating priority encoder, taking `req[3:0]` and `last[1:0]` and returning `found` and `idx[1:0]`. It is instantiated once; the rest is the FSM plus output registers.

## Test plan
- Reset: hold `rst` high with random `req`/`data_in` → `grant`=0000, `sel`=00, `data_out`=00, `data_valid`=0, `busy`=0.
- Single requester: `req`=0100, lane2=2'b10 → `grant`=0100 and `sel`=10 one cycle later; `data_out`=10 with `data_valid`=1 one further cycle later.
- Fair rotation: `req`=1111, each requester drops after 3 cycles of grant, then reasserts → grant order 0,1,2,3,0 with zero-bubble handovers and `busy` held high.
- Release to idle: sole grantee 3 drops `req` → `grant`=0000 and `busy`=0 next cycle; `sel` stays 11; `data_valid` goes to 0 one cycle later.
- Timeout (macro on, `MAX_HOLD`=4): `req`=0011 held continuously → grant alternates 0,1 every 4 cycles. With `req`=0001 only, grant 0 persists indefinitely.
- Reset mid-grant: assert `rst` while `grant`=0010 → outputs clear immediately. After release with `req`=0110, the first grant is 1 (pointer reset to 3).
